// File: rtl/dmi_arb_buffer.sv
// DMI request arbiter and in-order response router for N_CH debug transports sharing one DM port.
// An outstanding-tag FIFO remembers which channel issued each request, and whether its response should be dropped.
module dmi_arb_buffer #(
   parameter int N_CH   = 2,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32,
   parameter int OP_W   = 2,
   parameter int RESP_W = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [N_CH-1:0]            ch_req_valid_i,
   output logic [N_CH-1:0]            ch_req_ready_o,
   input  logic [N_CH*ADDR_W-1:0]     ch_req_addr_i,
   input  logic [N_CH*DATA_W-1:0]     ch_req_data_i,
   input  logic [N_CH*OP_W-1:0]       ch_req_op_i,
   input  logic [N_CH-1:0]            ch_clear_i,
   output logic [N_CH-1:0]            ch_resp_valid_o,
   input  logic [N_CH-1:0]            ch_resp_ready_i,
   output logic [DATA_W-1:0]          ch_resp_data_o,
   output logic [RESP_W-1:0]          ch_resp_o,
   output logic                       dm_req_valid_o,
   input  logic                       dm_req_ready_i,
   output logic [ADDR_W-1:0]          dm_req_addr_o,
   output logic [DATA_W-1:0]          dm_req_data_o,
   output logic [OP_W-1:0]            dm_req_op_o,
   input  logic                       dm_resp_valid_i,
   output logic                       dm_resp_ready_o,
   input  logic [DATA_W-1:0]          dm_resp_data_i,
   input  logic [RESP_W-1:0]          dm_resp_i,
   output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
   output logic                       stray_resp_o
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [CH_W-1:0]  r_tag_ch [DEPTH];
   logic [DEPTH-1:0] r_tag_drop;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic [CH_W-1:0]  r_rr;
   logic             r_stray;

   logic [N_CH-1:0]  w_elig;
   logic             w_any;
   logic [CH_W-1:0]  w_grant;
   logic             w_full;
   logic             w_empty;
   logic             w_req_valid;
   logic             w_push;
   logic             w_pop;
   logic             w_stray_acc;
   logic [CH_W-1:0]  w_head_ch;
   logic             w_head_drop;

   function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_CH) s = s - N_CH;
      return CH_W'(s);
   endfunction

   assign w_elig      = ch_req_valid_i & ~ch_clear_i;
   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_head_ch   = r_tag_ch[r_rptr];
   assign w_head_drop = r_tag_drop[r_rptr];

   // First eligible channel at or after r_rr, wrapping.
   always_comb begin
      w_any   = 1'b0;
      w_grant = r_rr;
      for (int k = 0; k < N_CH; k++) begin
         if (!w_any && w_elig[rr_idx(r_rr, k)]) begin
            w_any   = 1'b1;
            w_grant = rr_idx(r_rr, k);
         end
      end
   end

   assign w_req_valid = rst_ni && w_any && !w_full;
   assign w_push      = w_req_valid && dm_req_ready_i;

   always_comb begin
      dm_req_valid_o = w_req_valid;
      dm_req_addr_o  = '0;
      dm_req_data_o  = '0;
      dm_req_op_o    = '0;
      ch_req_ready_o = '0;
      if (w_req_valid) begin
         dm_req_addr_o           = ch_req_addr_i[w_grant*ADDR_W +: ADDR_W];
         dm_req_data_o           = ch_req_data_i[w_grant*DATA_W +: DATA_W];
         dm_req_op_o             = ch_req_op_i[w_grant*OP_W +: OP_W];
         ch_req_ready_o[w_grant] = dm_req_ready_i;
      end
   end

   always_comb begin
      ch_resp_valid_o = '0;
      dm_resp_ready_o = 1'b0;
      w_pop           = 1'b0;
      w_stray_acc     = 1'b0;
      if (rst_ni) begin
         if (w_empty) begin
            dm_resp_ready_o = 1'b1;
            w_stray_acc     = dm_resp_valid_i;
         end else if (w_head_drop) begin
            dm_resp_ready_o = 1'b1;
            w_pop           = dm_resp_valid_i;
         end else begin
            ch_resp_valid_o[w_head_ch] = dm_resp_valid_i;
            dm_resp_ready_o            = ch_resp_ready_i[w_head_ch];
            w_pop                      = dm_resp_valid_i && ch_resp_ready_i[w_head_ch];
         end
      end
   end

   assign ch_resp_data_o = dm_resp_data_i;
   assign ch_resp_o      = dm_resp_i;
   assign outstanding_o  = r_count;
   assign stray_resp_o   = r_stray;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_rr       <= '0;
         r_stray    <= 1'b0;
         r_tag_drop <= '0;
         for (int i = 0; i < DEPTH; i++) r_tag_ch[i] <= '0;
      end else begin
         r_stray <= w_stray_acc;
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
            r_rr   <= rr_idx(w_grant, 1);
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
         // Stale slots may also get marked; harmless since a push always rewrites drop.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wptr == PTR_W'(i))) begin
               r_tag_ch[i]   <= w_grant;
               r_tag_drop[i] <= 1'b0;
            end else if (ch_clear_i[r_tag_ch[i]]) begin
               r_tag_drop[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmi_arb_buffer.sv
// Randomized scoreboard bench for dmi_arb_buffer: per-channel request queues and a tag queue model
// predict grants, routing, drops and stray flags; a negedge monitor compares against the DUT.
module tb_dmi_arb_buffer;
   localparam int N_CH   = 2;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int OP_W   = 2;
   localparam int RESP_W = 2;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b0;
   logic [N_CH-1:0]        ch_req_valid_i;
   logic [N_CH-1:0]        ch_req_ready_o;
   logic [N_CH*ADDR_W-1:0] ch_req_addr_i;
   logic [N_CH*DATA_W-1:0] ch_req_data_i;
   logic [N_CH*OP_W-1:0]   ch_req_op_i;
   logic [N_CH-1:0]        ch_clear_i;
   logic [N_CH-1:0]        ch_resp_valid_o;
   logic [N_CH-1:0]        ch_resp_ready_i;
   logic [DATA_W-1:0]      ch_resp_data_o;
   logic [RESP_W-1:0]      ch_resp_o;
   logic                   dm_req_valid_o;
   logic                   dm_req_ready_i;
   logic [ADDR_W-1:0]      dm_req_addr_o;
   logic [DATA_W-1:0]      dm_req_data_o;
   logic [OP_W-1:0]        dm_req_op_o;
   logic                   dm_resp_valid_i;
   logic                   dm_resp_ready_o;
   logic [DATA_W-1:0]      dm_resp_data_i;
   logic [RESP_W-1:0]      dm_resp_i;
   logic [CNT_W-1:0]       outstanding_o;
   logic                   stray_resp_o;

   dmi_arb_buffer #(.N_CH(N_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .OP_W(OP_W), .RESP_W(RESP_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ch_req_valid_i(ch_req_valid_i), .ch_req_ready_o(ch_req_ready_o),
      .ch_req_addr_i(ch_req_addr_i), .ch_req_data_i(ch_req_data_i), .ch_req_op_i(ch_req_op_i),
      .ch_clear_i(ch_clear_i), .ch_resp_valid_o(ch_resp_valid_o), .ch_resp_ready_i(ch_resp_ready_i),
      .ch_resp_data_o(ch_resp_data_o), .ch_resp_o(ch_resp_o),
      .dm_req_valid_o(dm_req_valid_o), .dm_req_ready_i(dm_req_ready_i),
      .dm_req_addr_o(dm_req_addr_o), .dm_req_data_o(dm_req_data_o), .dm_req_op_o(dm_req_op_o),
      .dm_resp_valid_i(dm_resp_valid_i), .dm_resp_ready_o(dm_resp_ready_o),
      .dm_resp_data_i(dm_resp_data_i), .dm_resp_i(dm_resp_i),
      .outstanding_o(outstanding_o), .stray_resp_o(stray_resp_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [OP_W-1:0]   op;
   } req_t;

   req_t req_q [N_CH][$];   // pending requests per channel (front is being presented)
   int   tch_q[$];          // model of outstanding tags: issuing channel
   bit   tdr_q[$];          // model of outstanding tags: drop flag
   int   m_rr;
   bit   exp_stray;
   bit   resp_hs_flag;
   bit   done;
   int   n_cmp, n_bad;
   int   p_req, p_rdy, p_resp, p_clr, p_crdy;

   bit [N_CH-1:0] elig;
   bit            any_el, full, exp_req_v, exp_rr, pop, stray_next;
   int            g, c, h;
   logic [N_CH-1:0] exp_crv;
   req_t          fr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      if (!done) begin
         if (!rst_ni) begin
            check("rst_dm_req_valid", dm_req_valid_o, 0);
            check("rst_ch_req_ready", ch_req_ready_o, 0);
            check("rst_ch_resp_valid", ch_resp_valid_o, 0);
            check("rst_dm_resp_ready", dm_resp_ready_o, 0);
            check("rst_stray", stray_resp_o, 0);
            check("rst_outstanding", outstanding_o, 0);
            tch_q.delete();
            tdr_q.delete();
            m_rr = 0;
            exp_stray = 0;
            resp_hs_flag = 0;
         end else begin
            for (int i = 0; i < N_CH; i++) elig[i] = ch_req_valid_i[i] && !ch_clear_i[i];
            any_el = 0;
            g = 0;
            for (int k = 0; k < N_CH; k++) begin
               c = (m_rr + k) % N_CH;
               if (!any_el && elig[c]) begin
                  any_el = 1;
                  g = c;
               end
            end
            full = (tch_q.size() == DEPTH);
            exp_req_v = any_el && !full;
            check("outstanding", outstanding_o, tch_q.size());
            check("dm_req_valid", dm_req_valid_o, exp_req_v);
            if (exp_req_v) begin
               fr = req_q[g][0];
               check("dm_req_addr", dm_req_addr_o, fr.addr);
               check("dm_req_data", dm_req_data_o, fr.data);
               check("dm_req_op", dm_req_op_o, fr.op);
               check("ch_req_ready", ch_req_ready_o, dm_req_ready_i ? (64'd1 << g) : 64'd0);
            end else begin
               check("dm_req_addr_idle", dm_req_addr_o, 0);
               check("dm_req_data_idle", dm_req_data_o, 0);
               check("dm_req_op_idle", dm_req_op_o, 0);
               check("ch_req_ready_idle", ch_req_ready_o, 0);
            end

            exp_crv = '0;
            stray_next = 0;
            pop = 0;
            if (tch_q.size() == 0) begin
               exp_rr = 1;
               stray_next = dm_resp_valid_i;
            end else if (tdr_q[0]) begin
               exp_rr = 1;
               pop = dm_resp_valid_i;
            end else begin
               h = tch_q[0];
               exp_crv[h] = dm_resp_valid_i;
               exp_rr = ch_resp_ready_i[h];
               pop = dm_resp_valid_i && ch_resp_ready_i[h];
            end
            check("ch_resp_valid", ch_resp_valid_o, exp_crv);
            check("dm_resp_ready", dm_resp_ready_o, exp_rr);
            if (exp_crv != 0) begin
               check("ch_resp_data", ch_resp_data_o, dm_resp_data_i);
               check("ch_resp_code", ch_resp_o, dm_resp_i);
            end
            check("stray_resp", stray_resp_o, exp_stray);
            exp_stray = stray_next;
            resp_hs_flag = dm_resp_valid_i && exp_rr;

            if (pop) begin
               void'(tch_q.pop_front());
               void'(tdr_q.pop_front());
            end
            for (int k = 0; k < tch_q.size(); k++)
               if (ch_clear_i[tch_q[k]]) tdr_q[k] = 1;
            if (exp_req_v && dm_req_ready_i) begin
               tch_q.push_back(g);
               tdr_q.push_back(0);
               void'(req_q[g].pop_front());
               m_rr = (g + 1) % N_CH;
            end
         end
      end
   end

   task automatic drive();
      req_t r;
      if (resp_hs_flag) dm_resp_valid_i = 1'b0;
      if (!dm_resp_valid_i && ($urandom_range(0, 99) < p_resp)) begin
         dm_resp_valid_i = 1'b1;
         dm_resp_data_i  = $urandom;
         dm_resp_i       = RESP_W'($urandom_range(0, 3));
      end
      for (int i = 0; i < N_CH; i++) begin
         if (req_q[i].size() == 0 && ($urandom_range(0, 99) < p_req)) begin
            r.addr = ADDR_W'($urandom);
            r.data = $urandom;
            r.op   = OP_W'($urandom);
            req_q[i].push_back(r);
         end
         if (req_q[i].size() > 0) begin
            r = req_q[i][0];
            ch_req_valid_i[i] = 1'b1;
         end else begin
            r = '0;
            ch_req_valid_i[i] = 1'b0;
         end
         ch_req_addr_i[i*ADDR_W +: ADDR_W] = r.addr;
         ch_req_data_i[i*DATA_W +: DATA_W] = r.data;
         ch_req_op_i[i*OP_W +: OP_W]       = r.op;
         ch_clear_i[i]      = ($urandom_range(0, 99) < p_clr);
         ch_resp_ready_i[i] = ($urandom_range(0, 99) < p_crdy);
      end
      dm_req_ready_i = ($urandom_range(0, 99) < p_rdy);
   endtask

   // {p_req, p_rdy, p_resp, p_clr, p_crdy} per phase
   int phases [6][5] = '{
      '{100, 100, 50,  0, 100},
      '{ 80,  30, 40,  5,  60},
      '{100, 100,  0,  0, 100},
      '{ 60,  70, 70, 10,  50},
      '{ 90,  90, 20,  3,  30},
      '{  0, 100, 90,  0, 100}
   };

   initial begin
      n_cmp = 0; n_bad = 0; done = 0;
      m_rr = 0; exp_stray = 0; resp_hs_flag = 0;
      ch_req_valid_i = '1; ch_req_addr_i = '1; ch_req_data_i = '1; ch_req_op_i = '1;
      ch_clear_i = '0; ch_resp_ready_i = '1; dm_req_ready_i = 1'b1;
      dm_resp_valid_i = 1'b1; dm_resp_data_i = '0; dm_resp_i = '0;
      p_req = 0; p_rdy = 0; p_resp = 0; p_clr = 0; p_crdy = 0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      dm_resp_valid_i = 1'b0;
      for (int ph = 0; ph < 6; ph++) begin
         p_req  = phases[ph][0];
         p_rdy  = phases[ph][1];
         p_resp = phases[ph][2];
         p_clr  = phases[ph][3];
         p_crdy = phases[ph][4];
         for (int cyc = 0; cyc < 300; cyc++) begin
            drive();
            @(posedge clk_i);
            #1;
         end
         if (ph == 1 || ph == 3) begin
            rst_ni = 1'b0;
            repeat (2) @(posedge clk_i);
            #1;
            rst_ni = 1'b1;
         end
      end
      @(negedge clk_i);
      done = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
